i3c_xfer_sequencer: RTL and testbench

Parametrised multi-byte I3C transfer sequencer. It replaces the single-byte START/ADDRESS/DATA/STOP controller with one that handles:
- configurable burst length
- read/write direction
- bounded address-NACK retries via repeated START
- abort
- an optional per-phase ACK timeout

It sits between the host command interface and the bit-level SDA/SCL engine, which reports ACK outcomes through valid-qualified strobes.

---
 rtl/i3c_xfer_sequencer.sv | 124 ++++++++++++
 tb/tb_i3c_xfer_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i3c_xfer_sequencer.sv
// i3c_xfer_sequencer: multi-byte I3C START/ADDRESS/DATA/STOP sequencer with NACK retry and abort.
// Optional ACK timeout in ADDRESS/DATA enabled by defining I3C_XFER_TIMEOUT_EN.
module i3c_xfer_sequencer #(
  parameter int MAX_BYTES      = 16,
  parameter int LEN_W          = $clog2(MAX_BYTES + 1),
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             rd_nwr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic             addr_valid_i,
  input  logic             addr_acked_i,
  input  logic             data_valid_i,
  input  logic             data_acked_i,
  output logic [2:0]       state_o,
  output logic             rd_nwr_o,
  output logic [LEN_W-1:0] byte_idx_o,
  output logic [1:0]       retry_cnt_o,
  output logic             busy_o,
  output logic             transfer_complete_o,
  output logic             error_o,
  output logic [1:0]       err_code_o
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    ADDRESS = 3'd2,
    DATA    = 3'd3,
    STOP    = 3'd4,
    ERROR   = 3'd5,
    RESTART = 3'd6
  } state_t;
  state_t           state;
  logic [LEN_W-1:0] len, byte_idx, len_clamped;
  logic [1:0]       retry_cnt, err_code;
  logic             rd_nwr, tmo;
  assign len_clamped = (len_i > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len_i;
`ifdef I3C_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          waiting, strobe;
  assign waiting = (state == ADDRESS) || (state == DATA);
  assign strobe  = (state == ADDRESS && addr_valid_i) || (state == DATA && data_valid_i);
  // Fires on the cycle the count would reach TIMEOUT_CYCLES; a strobe in that cycle wins.
  assign tmo     = waiting && !strobe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) tmo_cnt <= '0;
    else tmo_cnt <= (!waiting || strobe) ? '0 : tmo_cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= IDLE;
      len       <= '0;
      rd_nwr    <= 1'b0;
      byte_idx  <= '0;
      retry_cnt <= '0;
      err_code  <= '0;
    end else begin
      case (state)
        IDLE:
          if (start_i) begin
            state     <= START;
            len       <= len_clamped;
            rd_nwr    <= rd_nwr_i;
            byte_idx  <= '0;
            retry_cnt <= '0;
            err_code  <= '0;
          end
        START, RESTART:
          if (abort_i) begin
            state    <= STOP;
            err_code <= 2'd3;
          end else state <= ADDRESS;
        ADDRESS:
          if (abort_i) begin
            state    <= STOP;
            err_code <= 2'd3;
          end else if (addr_valid_i) begin
            if (addr_acked_i) state <= (len == '0) ? STOP : DATA;
            else if (int'(retry_cnt) < MAX_RETRIES) begin
              state     <= RESTART;
              retry_cnt <= retry_cnt + {1'b0, retry_cnt != 2'd3};
            end else begin
              state    <= ERROR;
              err_code <= 2'd1;
            end
          end else if (tmo) begin
            state    <= ERROR;
            err_code <= 2'd3;
          end
        DATA:
          if (abort_i) begin
            state    <= STOP;
            err_code <= 2'd3;
          end else if (data_valid_i) begin
            if (data_acked_i) begin
              byte_idx <= byte_idx + 1'b1;
              if (byte_idx + 1'b1 == len) state <= STOP;
            end else begin
              state    <= ERROR;
              err_code <= 2'd2;
            end
          end else if (tmo) begin
            state    <= ERROR;
            err_code <= 2'd3;
          end
        default: state <= IDLE;
      endcase
    end
  assign state_o             = state;
  assign rd_nwr_o            = rd_nwr;
  assign byte_idx_o          = byte_idx;
  assign retry_cnt_o         = retry_cnt;
  assign busy_o              = state != IDLE;
  assign transfer_complete_o = state == STOP && err_code == 2'd0;
  assign error_o             = state == ERROR;
  assign err_code_o          = err_code;
endmodule

// File: tb/tb_i3c_xfer_sequencer.sv
// tb_i3c_xfer_sequencer: vector table, directed corner cases and random transfers checked
// against a transaction-level outcome model.
module tb_i3c_xfer_sequencer;
  localparam int MAXB  = 16;
  localparam int MAXR  = 3;
  localparam int LW    = 5;
  localparam int TMO   = 8;
  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 0, rd_nwr_i = 0, abort_i = 0;
  logic [LW-1:0] len_i = '0;
  logic          addr_valid_i = 0, addr_acked_i = 0, data_valid_i = 0, data_acked_i = 0;
  logic [2:0]    state_o;
  logic          rd_nwr_o, busy_o, transfer_complete_o, error_o;
  logic [LW-1:0] byte_idx_o;
  logic [1:0]    retry_cnt_o, err_code_o;
  int errors = 0, checks = 0, pulses = 0, errs = 0, restarts = 0;

  i3c_xfer_sequencer #(.MAX_BYTES(MAXB), .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .rd_nwr_i(rd_nwr_i), .len_i(len_i),
    .abort_i(abort_i), .addr_valid_i(addr_valid_i), .addr_acked_i(addr_acked_i),
    .data_valid_i(data_valid_i), .data_acked_i(data_acked_i), .state_o(state_o),
    .rd_nwr_o(rd_nwr_o), .byte_idx_o(byte_idx_o), .retry_cnt_o(retry_cnt_o), .busy_o(busy_o),
    .transfer_complete_o(transfer_complete_o), .error_o(error_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (transfer_complete_o) pulses++;
    if (error_o) errs++;
    if (state_o == 3'd6) restarts++;
  end

  typedef struct {
    int start, rd, len, abort, av, aa, dv, da;
    int es, eb, ee, ec, erd;
  } vec_t;
  vec_t tbl [0:25];

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drives one whole transfer and checks its end result against the outcome
  // predicted from len, NACK count and the byte at which a data NACK / abort occurs.
  task automatic run_xfer(input string nm, input int len, input int rd, input int nacks,
                          input int dnack, input int abrt);
    int n, eb, er, ee, ep, eerr, p0, e0, r0;
    n  = len > MAXB ? MAXB : len;
    er = nacks > MAXR ? MAXR : nacks;
    eb = 0; ee = 0; ep = 0; eerr = 0;
    if (nacks > MAXR) begin ee = 1; eerr = 1; end
    else if (abrt < n && abrt <= dnack) begin eb = abrt; ee = 3; end
    else if (dnack < n) begin eb = dnack; ee = 2; eerr = 1; end
    else begin eb = n; ep = 1; end
    p0 = pulses; e0 = errs; r0 = restarts;
    start_i = 1; len_i = LW'(len); rd_nwr_i = rd[0];
    cyc();
    start_i = 0; len_i = LW'($urandom); rd_nwr_i = ~rd[0];
    cyc();
    for (int a = 0; a <= nacks && a <= MAXR; a++) begin
      repeat ($urandom_range(0, 4)) cyc();
      addr_valid_i = 1; addr_acked_i = (a == nacks);
      cyc();
      addr_valid_i = 0; addr_acked_i = 0;
      if (a < nacks && a < MAXR) cyc();
    end
    if (nacks <= MAXR)
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 4)) cyc();
        if (b == abrt) begin
          abort_i = 1; data_valid_i = 1'($urandom); data_acked_i = 1;
          cyc();
          abort_i = 0; data_valid_i = 0; data_acked_i = 0;
          break;
        end
        data_valid_i = 1; data_acked_i = (b != dnack);
        cyc();
        data_valid_i = 0; data_acked_i = 0;
        if (b == dnack) break;
      end
    repeat (3) cyc();
    chk({nm, ".state"}, int'(state_o), 0);
    chk({nm, ".byte_idx"}, int'(byte_idx_o), eb);
    chk({nm, ".retry_cnt"}, int'(retry_cnt_o), er);
    chk({nm, ".err_code"}, int'(err_code_o), ee);
    chk({nm, ".pulses"}, pulses - p0, ep);
    chk({nm, ".error_cycles"}, errs - e0, eerr);
    chk({nm, ".restarts"}, restarts - r0, er);
    chk({nm, ".rd_nwr"}, int'(rd_nwr_o), rd & 1);
  endtask

  initial begin
    tbl[0]  = '{1,0,3,0,0,0,0,0, 1,0,0,0,0};
    tbl[1]  = '{0,0,0,0,0,0,0,0, 2,0,0,0,0};
    tbl[2]  = '{0,0,0,0,1,1,0,0, 3,0,0,0,0};
    tbl[3]  = '{0,0,0,0,0,0,1,1, 3,1,0,0,0};
    tbl[4]  = '{0,0,0,0,0,0,1,1, 3,2,0,0,0};
    tbl[5]  = '{0,0,0,0,0,0,1,1, 4,3,0,1,0};
    tbl[6]  = '{0,0,0,0,0,0,0,0, 0,3,0,0,0};
    tbl[7]  = '{1,1,4,0,0,0,0,0, 1,0,0,0,1};
    tbl[8]  = '{0,0,0,0,0,0,0,0, 2,0,0,0,1};
    tbl[9]  = '{0,0,0,0,1,1,0,0, 3,0,0,0,1};
    tbl[10] = '{0,0,0,0,0,0,1,1, 3,1,0,0,1};
    tbl[11] = '{0,0,0,1,0,0,1,1, 4,1,3,0,1};
    tbl[12] = '{0,0,0,1,0,0,0,0, 0,1,3,0,1};
    tbl[13] = '{0,0,0,1,0,0,0,0, 0,1,3,0,1};
    tbl[14] = '{1,0,0,0,0,0,0,0, 1,0,0,0,0};
    tbl[15] = '{0,0,0,0,0,0,0,0, 2,0,0,0,0};
    tbl[16] = '{0,0,0,0,1,1,0,0, 4,0,0,1,0};
    tbl[17] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0};
    tbl[18] = '{1,0,2,0,0,0,0,0, 1,0,0,0,0};
    tbl[19] = '{1,1,5,0,0,0,0,0, 2,0,0,0,0};
    tbl[20] = '{0,0,0,0,0,0,1,1, 2,0,0,0,0};
    tbl[21] = '{0,0,0,0,1,1,0,0, 3,0,0,0,0};
    tbl[22] = '{0,0,0,0,1,1,0,0, 3,0,0,0,0};
    tbl[23] = '{0,0,0,0,0,0,1,1, 3,1,0,0,0};
    tbl[24] = '{0,0,0,0,0,0,1,1, 4,2,0,1,0};
    tbl[25] = '{0,0,0,0,0,0,0,0, 0,2,0,0,0};

    repeat (3) cyc();
    chk("rst.state", int'(state_o), 0);
    chk("rst.outputs", int'({rd_nwr_o, byte_idx_o, retry_cnt_o, busy_o,
                             transfer_complete_o, error_o, err_code_o}), 0);
    rst_ni = 1;
    cyc();

    for (int i = 0; i < 26; i++) begin
      start_i = tbl[i].start[0]; rd_nwr_i = tbl[i].rd[0]; len_i = LW'(tbl[i].len);
      abort_i = tbl[i].abort[0]; addr_valid_i = tbl[i].av[0]; addr_acked_i = tbl[i].aa[0];
      data_valid_i = tbl[i].dv[0]; data_acked_i = tbl[i].da[0];
      cyc();
      chk($sformatf("tbl%0d.state", i), int'(state_o), tbl[i].es);
      chk($sformatf("tbl%0d.byte_idx", i), int'(byte_idx_o), tbl[i].eb);
      chk($sformatf("tbl%0d.err_code", i), int'(err_code_o), tbl[i].ee);
      chk($sformatf("tbl%0d.complete", i), int'(transfer_complete_o), tbl[i].ec);
      chk($sformatf("tbl%0d.rd_nwr", i), int'(rd_nwr_o), tbl[i].erd);
      chk($sformatf("tbl%0d.busy", i), int'(busy_o), int'(tbl[i].es != 0));
    end
    {start_i, abort_i, addr_valid_i, addr_acked_i, data_valid_i, data_acked_i} = '0;
    cyc();

    run_xfer("nack2", 1, 1, 2, 99, 99);
    run_xfer("nack4", 1, 0, 4, 99, 99);
    run_xfer("dnack", 4, 0, 0, 1, 99);
    run_xfer("clamp", MAXB + 5, 1, 0, 99, 99);
    run_xfer("len0", 0, 0, 1, 99, 99);

    // Abort beats a simultaneous address NACK: no retry is consumed.
    start_i = 1; len_i = 5'd2; cyc(); start_i = 0; cyc();
    abort_i = 1; addr_valid_i = 1; addr_acked_i = 0; cyc();
    abort_i = 0; addr_valid_i = 0;
    chk("abort_addr.state", int'(state_o), 4);
    chk("abort_addr.err_code", int'(err_code_o), 3);
    chk("abort_addr.retry_cnt", int'(retry_cnt_o), 0);
    chk("abort_addr.complete", int'(transfer_complete_o), 0);
    cyc();

    // Asynchronous reset in the middle of DATA.
    start_i = 1; len_i = 5'd3; cyc(); start_i = 0; cyc();
    addr_valid_i = 1; addr_acked_i = 1; cyc(); addr_valid_i = 0;
    data_valid_i = 1; data_acked_i = 1; cyc(); data_valid_i = 0;
    #2 rst_ni = 0;
    #1;
    chk("midrst.state", int'(state_o), 0);
    chk("midrst.flags", int'({transfer_complete_o, error_o, busy_o, byte_idx_o}), 0);
    cyc(); rst_ni = 1; cyc();

    start_i = 1; len_i = 5'd1; cyc(); start_i = 0; cyc();
`ifdef I3C_XFER_TIMEOUT_EN
    repeat (TMO - 1) cyc();
    chk("tmo.before", int'(state_o), 2);
    cyc();
    chk("tmo.state", int'(state_o), 5);
    chk("tmo.err_code", int'(err_code_o), 3);
    chk("tmo.error", int'(error_o), 1);
    cyc();
    start_i = 1; len_i = 5'd1; cyc(); start_i = 0; cyc();
    repeat (TMO - 1) cyc();
    addr_valid_i = 1; addr_acked_i = 1; cyc(); addr_valid_i = 0;
    chk("tmo.strobe_wins", int'(state_o), 3);
    abort_i = 1; cyc(); abort_i = 0; cyc();
`else
    repeat (1000) cyc();
    chk("notmo.state", int'(state_o), 2);
    chk("notmo.err_code", int'(err_code_o), 0);
    abort_i = 1; cyc(); abort_i = 0;
    chk("notmo.abort", int'(state_o), 4);
    cyc();
`endif

    for (int t = 0; t < 40; t++) begin
      int len, nacks, dn, ab;
      len   = $urandom_range(0, 20);
      nacks = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
      dn    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : 99;
      ab    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16) : 99;
      run_xfer($sformatf("rnd%0d", t), len, int'($urandom_range(0, 1)), nacks, dn, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
